// File: rtl/div_arb_pkg.sv
// Shared definitions for the std_div_arb divider arbiter: op codes, FSM states
// and the round-robin grant search.
package div_arb_pkg;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MOD  = 1'b1;
    localparam int   MAX_REQ = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index of the first set request at or above ptr, wrapping at n; ptr when none is set.
    function automatic int unsigned rrNext(input logic [MAX_REQ-1:0] reqs,
                                           input int unsigned        ptr,
                                           input int unsigned        n);
        int unsigned idx;
        logic        found;
        rrNext = ptr;
        found  = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (ptr + k) % n;
            if (k < n && !found && reqs[idx[5:0]]) begin
                rrNext = idx;
                found  = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/std_div_arb_core.sv
// Serial restoring unsigned divider: one quotient bit per cycle, result valid
// width cycles after start. Divide by zero gives an all-ones quotient and remainder = left.
module std_div_arb_core #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             valid
);
    localparam int            DW   = 2 * width - 1;
    localparam int            CW   = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width);

    logic [DW-1:0]    divisor_q, divisor_d;
    logic [width-1:0] dividend_q, dividend_d;
    logic [width-1:0] quotient_q, quotient_d;
    logic [width-1:0] mask_q, mask_d;
    logic [CW-1:0]    count_q, count_d;
    logic             active_q, active_d;
    logic             fits;

    // The divisor slides right past the dividend; a zero divisor always fits.
    assign fits = divisor_q <= DW'(dividend_q);

    always_comb begin
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        quotient_d = quotient_q;
        mask_d     = mask_q;
        count_d    = count_q;
        active_d   = active_q;
        if (start) begin
            divisor_d  = DW'(right) << (width - 1);
            dividend_d = left;
            quotient_d = '0;
            mask_d     = {1'b1, {(width-1){1'b0}}};
            count_d    = '0;
            active_d   = 1'b1;
        end else if (active_q && count_q != LAST) begin
            if (fits) begin
                dividend_d = dividend_q - divisor_q[width-1:0];
                quotient_d = quotient_q | mask_q;
            end
            divisor_d = divisor_q >> 1;
            mask_d    = mask_q >> 1;
            count_d   = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            divisor_q  <= '0;
            dividend_q <= '0;
            quotient_q <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            active_q   <= 1'b0;
        end else begin
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            quotient_q <= quotient_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            active_q   <= active_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = dividend_q;
    assign valid     = active_q && (count_q == LAST);

endmodule

// File: rtl/std_div_arb.sv
// Round-robin arbiter sharing one serial divider between NUM_REQ go/done requesters.
// Define DIV_ARB_SIGNED_EN to honour req_signed (two's-complement div/mod).
module std_div_arb
    import div_arb_pkg::*;
#(
    parameter int width   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_go,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ-1:0]       req_signed,
    input  logic [NUM_REQ*width-1:0] req_left,
    input  logic [NUM_REQ*width-1:0] req_right,
    output logic [width-1:0]         out,
    output logic [NUM_REQ-1:0]       done
);
    localparam int            IW        = $clog2(NUM_REQ);
    localparam int            CW        = $clog2(width);
    localparam logic [CW-1:0] LAST_ITER = CW'(width - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          op_q, op_d;
    logic [CW-1:0] iter_q, iter_d;

    logic             anyGo, start, coreValid;
    logic [IW-1:0]    pick, nextPtr;
    logic [width-1:0] selLeft, selRight, coreLeft, coreRight;
    logic [width-1:0] coreQuot, coreRem, result;

    assign anyGo    = |req_go;
    assign pick     = IW'(rrNext(MAX_REQ'(req_go), 32'(rr_q), 32'(NUM_REQ)));
    assign selLeft  = req_left[pick*width +: width];
    assign selRight = req_right[pick*width +: width];
    assign start    = (state_q == IDLE) && anyGo;
    assign nextPtr  = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Only the granted requester's go matters while busy; dropping it abandons the operation.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        op_d    = op_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (anyGo) begin
                    grant_d = pick;
                    op_d    = req_op[pick];
                    iter_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_go[grant_q]) begin
                    state_d = IDLE;
                    rr_d    = nextPtr;
                end else if (iter_q == LAST_ITER) begin
                    state_d = RESP;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = nextPtr;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            op_q    <= OP_DIV;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            iter_q  <= iter_d;
        end
    end

`ifdef DIV_ARB_SIGNED_EN
    logic             sgn_q, leftNeg_q, rightNeg_q;
    logic [width-1:0] right_q;
    logic             selSigned;

    // The core only sees magnitudes; signs are remembered and applied to the result.
    assign selSigned = req_signed[pick];
    assign coreLeft  = (selSigned && selLeft[width-1])  ? -selLeft  : selLeft;
    assign coreRight = (selSigned && selRight[width-1]) ? -selRight : selRight;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sgn_q      <= 1'b0;
            leftNeg_q  <= 1'b0;
            rightNeg_q <= 1'b0;
            right_q    <= '0;
        end else if (start) begin
            sgn_q      <= selSigned;
            leftNeg_q  <= selLeft[width-1];
            rightNeg_q <= selRight[width-1];
            right_q    <= selRight;
        end
    end

    // Quotient truncates toward zero; a nonzero remainder of a negative dividend folds to right - rem.
    always_comb begin
        if (op_q == OP_MOD) begin
            result = (sgn_q && leftNeg_q && coreRem != '0) ? right_q - coreRem : coreRem;
        end else begin
            result = (sgn_q && (leftNeg_q ^ rightNeg_q)) ? -coreQuot : coreQuot;
        end
    end
`else
    logic unusedSigned;
    assign unusedSigned = ^req_signed;
    assign coreLeft     = selLeft;
    assign coreRight    = selRight;
    assign result       = (op_q == OP_MOD) ? coreRem : coreQuot;
`endif

    std_div_arb_core #(.width(width)) core (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .left      (coreLeft),
        .right     (coreRight),
        .quotient  (coreQuot),
        .remainder (coreRem),
        .valid     (coreValid)
    );

    always_comb begin
        out  = '0;
        done = '0;
        if (state_q == RESP && coreValid) begin
            out           = result;
            done[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_std_div_arb.sv
// Self-checking bench for std_div_arb (width=8, NUM_REQ=4): a cycle-level behavioural
// model checked every cycle, directed scenarios with literal expectations, and a random soak.
`timescale 1ns/1ps
module tb_std_div_arb;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk        = 1'b0;
    logic           reset_n    = 1'b0;
    logic [N-1:0]   req_go     = '0;
    logic [N-1:0]   req_op     = '0;
    logic [N-1:0]   req_signed = '0;
    logic [N*W-1:0] req_left   = '0;
    logic [N*W-1:0] req_right  = '0;
    logic [W-1:0]   out;
    logic [N-1:0]   done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    std_div_arb #(.width(W), .NUM_REQ(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_go     (req_go),
        .req_op     (req_op),
        .req_signed (req_signed),
        .req_left   (req_left),
        .req_right  (req_right),
        .out        (out),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [W-1:0] refResult(input logic op, input logic sgn,
                                               input logic [W-1:0] l, input logic [W-1:0] r);
        int sl, sr;
        if (sgn) begin
            sl = $signed(l);
            sr = $signed(r);
            return op ? W'(((sl % sr) + sr) % sr) : W'(sl / sr);
        end
        if (r == 0) return op ? l : {W{1'b1}};
        return op ? l % r : l / r;
    endfunction

    // Behavioural model: phase 0 waiting, 1 computing, 2 answering.
    int           mPhase = 0;
    int           mBusyEdges = 0;
    int           mGrant = 0;
    int           mRr = 0;
    logic         mOp = 1'b0;
    logic         mSgn = 1'b0;
    logic [W-1:0] mL = '0;
    logic [W-1:0] mR = '0;
    bit           mValid = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mPhase = 0;
            mRr    = 0;
            mValid = 1'b1;
        end else if (mValid) begin
            case (mPhase)
                0: if (req_go != 0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req_go[(mRr + k) % N]) mGrant = (mRr + k) % N;
                    mOp  = req_op[mGrant];
                    mL   = req_left[mGrant*W +: W];
                    mR   = req_right[mGrant*W +: W];
                    mSgn = 1'b0;
`ifdef DIV_ARB_SIGNED_EN
                    mSgn = req_signed[mGrant];
`endif
                    mBusyEdges = 0;
                    mPhase     = 1;
                end
                1: if (!req_go[mGrant]) begin
                    mPhase = 0;
                    mRr    = (mGrant + 1) % N;
                end else begin
                    mBusyEdges++;
                    if (mBusyEdges == W) mPhase = 2;
                end
                default: begin
                    mPhase = 0;
                    mRr    = (mGrant + 1) % N;
                end
            endcase
        end
    end

    // Every cycle after the first reset edge, outputs must match the model.
    logic [N-1:0] expDone;
    logic [W-1:0] expOut;
    logic [N-1:0] seenDone = '0;

    always @(negedge clk) begin
        if (mValid) begin
            expDone = (mPhase == 2) ? N'(1 << mGrant) : '0;
            expOut  = (mPhase == 2) ? refResult(mOp, mSgn, mL, mR) : '0;
            checkOutput("model done", done, expDone);
            checkOutput("model out", out, expOut);
        end
        seenDone = done;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int idx, input logic op, input logic [W-1:0] l,
                                 input logic [W-1:0] r, input logic sgn);
        req_op[idx]         = op;
        req_left[idx*W +: W]  = l;
        req_right[idx*W +: W] = r;
        req_signed[idx]     = sgn;
        req_go[idx]         = 1'b1;
    endtask

    task automatic waitDone(input string name, input int limit, output int doneCyc,
                            output logic [N-1:0] doneVec, output logic [W-1:0] doneOut);
        doneCyc = -1;
        doneVec = '0;
        doneOut = '0;
        for (int i = 0; i < limit && doneCyc < 0; i++) begin
            @(negedge clk);
            if (done != 0) begin
                doneCyc = cyc;
                doneVec = done;
                doneOut = out;
            end
        end
        if (doneCyc < 0) checkOutput({name, " timeout"}, 0, 1);
    endtask

    // One isolated request from an idle arbiter: result, target, latency and pulse width.
    task automatic runOp(input string name, input int idx, input logic op, input logic [W-1:0] l,
                         input logic [W-1:0] r, input logic sgn, input logic [W-1:0] want);
        int           startCyc, dc;
        logic [N-1:0] dv;
        logic [W-1:0] dout;
        tick();
        applyStimulus(idx, op, l, r, sgn);
        startCyc = cyc;
        waitDone(name, 30, dc, dv, dout);
        checkOutput({name, " out"}, dout, want);
        checkOutput({name, " done"}, dv, N'(1 << idx));
        checkOutput({name, " latency"}, dc - startCyc, 9);
        tick();
        req_go[idx] = 1'b0;
        @(negedge clk);
        checkOutput({name, " pulse"}, done, '0);
    endtask

    initial begin
        int           dc, idx, relCyc;
        int           order[6];
        int           dcs[6];
        int           expOrder[6] = '{0, 1, 2, 3, 0, 3};
        logic [N-1:0] dv;
        logic [W-1:0] dout;

        // All requesters ask from reset onward.
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, W'(30 + i * 17), W'(i + 2), 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset done", done, '0);
        checkOutput("reset out", out, '0);
        tick();
        reset_n = 1'b1;
        relCyc  = cyc;

        for (int s = 0; s < 6; s++) begin
            waitDone("fair", 40, dc, dv, dout);
            idx = 0;
            for (int i = 0; i < N; i++) if (dv[i]) idx = i;
            order[s] = idx;
            dcs[s]   = dc;
            tick();
            req_go[idx] = 1'b0;
            if (s == 1) req_go[0] = 1'b1;
            if (s == 3) begin
                tick();
                req_go[3] = 1'b1;
            end
        end
        checkOutput("fair first latency", dcs[0] - relCyc, 9);
        for (int s = 0; s < 6; s++) checkOutput($sformatf("fair order %0d", s), order[s], expOrder[s]);
        for (int s = 1; s < 4; s++) checkOutput($sformatf("fair spacing %0d", s), dcs[s] - dcs[s-1], 10);

        runOp("div 100/7", 0, 1'b0, 8'd100, 8'd7, 1'b0, 8'd14);
        runOp("mod 100%7", 2, 1'b1, 8'd100, 8'd7, 1'b0, 8'd2);
        runOp("div 0/5", 2, 1'b0, 8'd0, 8'd5, 1'b0, 8'd0);
        runOp("div 37/0", 1, 1'b0, 8'd37, 8'd0, 1'b0, 8'd255);
        runOp("mod 37%0", 1, 1'b1, 8'd37, 8'd0, 1'b0, 8'd37);
        runOp("udiv F9/2", 0, 1'b0, 8'hF9, 8'd2, 1'b0, 8'd124);
`ifdef DIV_ARB_SIGNED_EN
        runOp("sdiv -7/2", 0, 1'b0, 8'hF9, 8'd2, 1'b1, 8'hFD);
        runOp("smod -7%2", 0, 1'b1, 8'hF9, 8'd2, 1'b1, 8'd1);
`endif

        // Requester 1 gives up in its third busy cycle; requester 2 is waiting.
        tick();
        applyStimulus(1, 1'b0, 8'd200, 8'd9, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 8'd200, 8'd9, 1'b0);
        tick();
        tick();
        req_go[1] = 1'b0;
        relCyc    = cyc;
        waitDone("abort", 30, dc, dv, dout);
        checkOutput("abort done", dv, 4'b0100);
        checkOutput("abort out", dout, 8'd22);
        checkOutput("abort latency", dc - relCyc, 10);
        tick();
        req_go[2] = 1'b0;

        // Reset in the middle of an operation, then show the pointer is back at 0.
        tick();
        applyStimulus(0, 1'b0, 8'd50, 8'd3, 1'b0);
        repeat (4) tick();
        reset_n   = 1'b0;
        req_go[0] = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("busy reset done", done, '0);
        checkOutput("busy reset out", out, '0);
        tick();
        reset_n = 1'b1;
        applyStimulus(1, 1'b0, 8'd90, 8'd10, 1'b0);
        applyStimulus(3, 1'b0, 8'd91, 8'd10, 1'b0);
        waitDone("post reset", 30, dc, dv, dout);
        checkOutput("post reset grant", dv, 4'b0010);
        checkOutput("post reset out", dout, 8'd9);
        tick();
        req_go[1] = 1'b0;
        waitDone("post reset 2", 30, dc, dv, dout);
        checkOutput("post reset grant 2", dv, 4'b1000);
        tick();
        req_go[3] = 1'b0;

        // Random soak: requests, back-to-back holds, occasional aborts.
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_go[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req_op[i]           = 1'($urandom_range(1));
                        req_signed[i]       = 1'b0;
                        req_left[i*W +: W]  = ($urandom_range(7) == 0) ? '0 : W'($urandom);
                        req_right[i*W +: W] = ($urandom_range(7) == 0) ? '0 : W'($urandom);
`ifdef DIV_ARB_SIGNED_EN
                        if ($urandom_range(1) == 1) begin
                            req_signed[i]       = 1'b1;
                            req_right[i*W +: W] = W'($urandom_range(127, 1));
                        end
`endif
                        req_go[i] = 1'b1;
                    end
                end else if (seenDone[i]) begin
                    if ($urandom_range(1) == 0) req_go[i] = 1'b0;
                end else if ($urandom_range(63) == 0) begin
                    req_go[i] = 1'b0;
                end
            end
        end
        tick();
        req_go = '0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/std_div_arb.md
Name: std_div_arb

Overview:
- Shares one serial restoring unsigned divider/modulo datapath between NUM_REQ requesters using go/done handshakes.
- Round-robin arbitration, fixed per-operation latency, one operation in flight.
- Sits between Calyx-generated groups and a single area-cheap divider, replacing per-site divider instances.

Parameters:
- width, 32, operand/result bit width (>=2)
- NUM_REQ, 4, number of requesters (>=2)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_go  in  NUM_REQ  per-requester go; held high until done
- req_op  in  NUM_REQ  per-requester op: 0 = div, 1 = mod
- req_signed  in  NUM_REQ  per-requester signed select; used only under DIV_ARB_SIGNED_EN
- req_left  in  NUM_REQ*width  dividends; slice i = [i*width +: width]
- req_right  in  NUM_REQ*width  divisors; same slicing
- out  out  width  result, valid while any done bit is high
- done  out  NUM_REQ  one-hot done pulse to the served requester

Behaviour:
- Reset (reset_n low at posedge): state IDLE, out=0, done=0, rr pointer=0, core cleared. Reset mid-operation discards the operation silently.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req_go is high, grant the first set bit searching upward from the rr pointer, wrapping.
  - Capture left, right, op, signed and grant index.
  - Start the core with iteration count 0; go to BUSY.
  - If no req_go is high, remain in IDLE.
- BUSY:
  - Core does one restoring step per cycle, for exactly width cycles.
  - Divisor is held width*2-1 bits wide, initialised to right << (width-1).
  - Quotient mask shifts right each cycle.
  - After the width-th step, go to RESP.
- Abort: if req_go[grant] drops in BUSY, go to IDLE next edge with no done. The rr pointer advances to grant+1. Other requesters do not affect the in-flight operation.
- RESP:
  - For one cycle: out = quotient (div) or remainder (mod), done[grant]=1.
  - rr pointer <= grant+1 mod NUM_REQ; go to IDLE.
  - All other cycles: done=0, out=0.
- Latency: done is high in the cycle following the width-th edge after the capture edge.
- Throughput: one operation per width+2 cycles.
- Back-to-back: a requester still holding go after done is a new request and competes at the next IDLE from the advanced pointer.
- Divide by zero: quotient = all ones; remainder = left. No special latency.
- left=0: normal path, result 0, same latency.
- Simultaneous: a go rising in the RESP cycle is seen in the following IDLE cycle. Grant is registered only in IDLE.

Optional Feature:
- DIV_ARB_SIGNED_EN defined, and req_signed[i]=1:
  - Operands are two's complement; the core is fed absolute values.
  - div truncates toward zero: negate if signs differ.
  - mod = ((l % r) + r) % r: if left is negative and the remainder is nonzero, result = right − remainder.
  - Same latency; sign correction is registered with RESP.
- Undefined: req_signed is ignored and all operations are unsigned; no sign logic is synthesised.

Decomposition:
- Package div_arb_pkg:
  - op encoding constants OP_DIV=1'b0, OP_MOD=1'b1
  - state enum typedef (IDLE/BUSY/RESP)
  - round-robin next-grant function
- Sub-module std_div_arb_core: serial restoring divider.
  - Inputs: clk, reset_n, start, left, right.
  - Outputs: quotient, remainder, valid.
  - Fixed width-cycle latency.

Test Plan (width=8, NUM_REQ=4):
- req 0: go, div, 100/7 -> done[0] only, out=14, exactly 8 edges after the capture edge; done high one cycle.
- req 2: mod 100%7 -> out=2. Then 0/5 div -> out=0 at same latency.
- go[0..3] all high from reset, each holding until done then dropping -> service order 0,1,2,3 at 10-cycle spacing. With 0 and 3 re-raised after their dones, 0 is served before 3 again.
- req 1: div 37/0 -> out=255; mod 37%0 -> out=37.
- req 1 granted, go[1] drops at BUSY cycle 3 while go[2] is high -> no done[1]; req 2 captured 2 cycles later. reset_n low during BUSY -> done=0, out=0, pointer=0.
- DIV_ARB_SIGNED_EN: signed −7/2 -> out=8'hFD (−3); signed −7 mod 2 -> out=1; unsigned 8'hF9/2 -> out=124.
